reg_rr_arbiter: RTL and testbench
=================================

Name: reg_rr_arbiter

Overview:
- Shares one 48-bit address / 32-bit data register-bus target (bootrom or FLL config port behind its AXI-Lite-to-reg bridge) among NumReq register-bus requesters.
- Arbitrates round-robin and holds the grant for the full transaction.
- Guards the target with a watchdog. A stalled target is answered with an error, so the interconnect never locks up.
- Sits between the requesters' reg_req_t/reg_rsp_t ports and a single target.

Parameters:
- NumReq, 4, number of requesters (>=2).
- TimeoutCycles, 256, BUSY cycles without target ready before abort; 0 disables the watchdog.
- TimeoutData, 32'hBADC_AB1E, rdata returned on timeout.
- req_t, reg_a48_d32_req_t, register-bus request type (valid, write, addr[47:0], wdata[31:0], wstrb[3:0]).
- rsp_t, reg_a48_d32_rsp_t, register-bus response type (ready, rdata[31:0], error).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset.
- req_i  input  NumReq x req_t  requester requests.
- rsp_o  output  NumReq x rsp_t  requester responses.
- req_o  output  req_t  request to the shared target.
- rsp_i  input  rsp_t  response from the target.
- busy_o  output  1  transaction in flight.
- grant_idx_o  output  $clog2(NumReq)  index of the current or last grant.
- timeout_o  output  1  one-cycle pulse when a transaction is aborted.
- timeout_idx_o  output  $clog2(NumReq)  requester of the most recent timeout (sticky).

Behaviour:
- Reset and clocking: one clock, clk_i; reset rst_ni is asynchronous, active-low. On reset:
  - state = IDLE; req_o all fields 0; every rsp_o = 0.
  - busy_o = 0, grant_idx_o = 0, timeout_o = 0, timeout_idx_o = 0.
  - Round-robin pointer = 0; watchdog counter = 0.
- Bus protocol: a requester raises valid and holds valid, write, addr, wdata and wstrb stable until it sees ready. ready is a single-cycle completion; rdata/error are valid only in that cycle.
- States: IDLE, BUSY.
- IDLE:
  - req_o.valid = 0; all rsp_o.ready = 0.
  - If any req_i[k].valid, pick the first valid index searching ptr, ptr+1, ... mod NumReq.
  - Latch it into idx (shown on grant_idx_o) and go to BUSY next cycle. No request is forwarded during the arbitration cycle.
- BUSY:
  - req_o = req_i[idx] (combinational passthrough); busy_o = 1.
  - rsp_o[idx] = rsp_i (combinational). Every other rsp_o = 0.
  - Watchdog counter increments each BUSY cycle in which rsp_i.ready = 0.
- BUSY, rsp_i.ready = 1: the transaction completes this cycle. Next state IDLE, ptr = (idx+1) mod NumReq, counter cleared.
- BUSY, TimeoutCycles != 0, counter == TimeoutCycles-1, rsp_i.ready = 0:
  - Abort: req_o.valid forced 0 this cycle.
  - rsp_o[idx] = {ready=1, rdata=TimeoutData, error=1}.
  - timeout_o = 1 for this cycle; timeout_idx_o <= idx.
  - Next state IDLE, ptr = idx+1, counter cleared.
- Simultaneous ready and timeout in the same cycle: ready wins, normal completion, no timeout_o.
- Requester drops valid in BUSY (protocol violation): req_o.valid follows it to 0. Return to IDLE next cycle with no response, ptr advances.
- Late target ready after an abort (in IDLE) is ignored and not forwarded.
- Throughput: at most one transaction per 2 cycles (arbitration + at least one BUSY cycle). Minimum latency from valid to ready is 2 cycles with a zero-wait target.
- Fairness: a requester that keeps valid high waits at most NumReq-1 other transactions.
- Reset asserted mid-BUSY: immediately returns to reset values. The in-flight transaction is dropped with no response.
- Width rules:
  - Counter width = $clog2(TimeoutCycles+1), saturating-safe, never wraps before the compare.
  - Pointer wrap from NumReq-1 goes to 0; grant_idx_o width is $clog2(NumReq).

Test Plan:
- Single write, requester 2 only, target ready on the first BUSY cycle, NumReq=4: req_o.addr/wdata equal requester 2's values; rsp_o[2].ready 2 cycles after valid; ptr=3.
- All 4 requesters valid continuously, zero-wait target: grants 0,1,2,3,0 in order; each rsp_o[k].ready exactly once per 8 cycles; no rsp_o on a non-granted index.
- Read with target wait 5 cycles, rdata 32'h1234_5678: requester sees ready on BUSY cycle 6 with rdata 32'h1234_5678 and error 0; busy_o high for 6 cycles.
- TimeoutCycles=8, target never ready, requester 1 valid: on BUSY cycle 8 rsp_o[1] = {ready=1, rdata=32'hBADC_AB1E, error=1}; timeout_o pulses once; timeout_idx_o=1; next grant goes to requester 2 if valid.
- Target ready in the same cycle the counter reaches TimeoutCycles-1: normal response, error follows rsp_i, timeout_o stays 0.
- rst_ni asserted mid-BUSY: outputs go to 0 asynchronously; after release the first grant is requester 0 when all are valid.

Source files
------------

// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter sharing one reg-bus target among NumReq requesters, with a stall watchdog.
// Latency: one arbitration cycle, then the request passes straight through until the target answers.
// Backpressure: losing requesters wait with valid high. A stalled target is answered with an error response.

package reg_rr_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [47:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_a48_d32_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_a48_d32_rsp_t;

endpackage

module reg_rr_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned TimeoutCycles = 256,
  parameter logic [31:0] TimeoutData   = 32'hBADC_AB1E,
  parameter type         req_t         = reg_rr_arbiter_pkg::reg_a48_d32_req_t,
  parameter type         rsp_t         = reg_rr_arbiter_pkg::reg_a48_d32_rsp_t,
  localparam int unsigned IdxW         = $clog2(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  req_t [NumReq-1:0]      req_i,
  output rsp_t [NumReq-1:0]      rsp_o,
  output req_t                   req_o,
  input  rsp_t                   rsp_i,
  output logic                   busy_o,
  output logic [IdxW-1:0]        grant_idx_o,
  output logic                   timeout_o,
  output logic [IdxW-1:0]        timeout_idx_o
);

  // Counter wide enough to hold TimeoutCycles-1 without wrapping; one bit when the watchdog is off.
  localparam int unsigned CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumReq - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          r_state;
  logic [IdxW-1:0] r_idx;
  logic [IdxW-1:0] r_ptr;
  logic [CntW-1:0] r_cnt;
  logic [IdxW-1:0] r_timeout_idx;
  logic            r_busy;

  logic            w_any;
  logic [IdxW-1:0] w_sel;
  logic            w_busy;
  logic            w_vld;
  logic            w_drop;
  logic            w_done;
  logic            w_abort;
  logic [IdxW-1:0] w_idx_next;

  // (base + off) mod NumReq, valid for off < NumReq.
  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= int'(NumReq)) sum = sum - int'(NumReq);
    return IdxW'(sum);
  endfunction

  // Pick the first valid requester at or after the pointer; scanning downward lets the nearest win.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (req_i[rr_idx(r_ptr, i)].valid) begin
        w_any = 1'b1;
        w_sel = rr_idx(r_ptr, i);
      end
    end
  end

  // Completion, abort and protocol-drop conditions for the granted requester.
  // A dropped valid wins, then target ready, then the watchdog.
  always_comb begin
    w_busy     = (r_state == BUSY);
    w_vld      = req_i[r_idx].valid;
    w_drop     = w_busy && !w_vld;
    w_done     = w_busy && w_vld && rsp_i.ready;
    w_abort    = (TimeoutCycles != 0) && w_busy && w_vld && !rsp_i.ready && (r_cnt == CntLast);
    w_idx_next = (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
  end

  // Combinational passthrough while BUSY. The abort cycle substitutes the error response.
  always_comb begin
    req_o     = '0;
    rsp_o     = '0;
    timeout_o = 1'b0;
    if (w_busy) begin
      req_o = req_i[r_idx];
      if (w_abort) begin
        req_o.valid          = 1'b0;
        rsp_o[r_idx].ready   = 1'b1;
        rsp_o[r_idx].rdata   = TimeoutData;
        rsp_o[r_idx].error   = 1'b1;
        timeout_o            = 1'b1;
      end else if (w_vld) begin
        rsp_o[r_idx] = rsp_i;
      end
    end
  end

  // Arbitration FSM with watchdog counter and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_timeout_idx <= '0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_idx   <= w_sel;
            r_state <= BUSY;
            r_busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (w_drop || w_done || w_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= w_idx_next;
            r_cnt   <= '0;
            if (w_abort) r_timeout_idx <= r_idx;
          end else if (r_cnt != {CntW{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign grant_idx_o   = r_idx;
  assign timeout_idx_o = r_timeout_idx;

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Directed bench for reg_rr_arbiter (NumReq=4, TimeoutCycles=8) with a latency-programmable target.
// Inputs change 1ns after the rising edge, and outputs are checked in that settled window.
// The target answers a configurable number of cycles after it first sees valid, or never.

module tb_reg_rr_arbiter;
  import reg_rr_arbiter_pkg::*;

  logic                      clk;
  logic                      rst_ni;
  reg_a48_d32_req_t [3:0]    req_s;
  reg_a48_d32_rsp_t [3:0]    rsp_s;
  reg_a48_d32_req_t          req_o;
  reg_a48_d32_rsp_t          rsp_i;
  logic                      busy_o;
  logic [1:0]                grant_idx_o;
  logic                      timeout_o;
  logic [1:0]                timeout_idx_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          tgt_lat = 0;
  int          tgt_cnt = 0;
  logic        tgt_force = 1'b0;
  logic        tgt_err   = 1'b0;
  logic [31:0] tgt_rdata = 32'h0;

  reg_rr_arbiter #(
    .NumReq        (4),
    .TimeoutCycles (8),
    .TimeoutData   (32'hBADC_AB1E)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req_s),
    .rsp_o         (rsp_s),
    .req_o         (req_o),
    .rsp_i         (rsp_i),
    .busy_o        (busy_o),
    .grant_idx_o   (grant_idx_o),
    .timeout_o     (timeout_o),
    .timeout_idx_o (timeout_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target: ready after tgt_lat cycles of seen valid; tgt_lat < 0 never answers.
  always_comb begin
    rsp_i       = '0;
    rsp_i.ready = tgt_force || (req_o.valid && tgt_lat >= 0 && tgt_cnt == tgt_lat);
    rsp_i.rdata = tgt_rdata;
    rsp_i.error = tgt_err;
  end

  always @(posedge clk) begin
    if (rsp_i.ready || !req_o.valid) tgt_cnt <= 0;
    else                             tgt_cnt <= tgt_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rdy_mask();
    logic [3:0] m;
    for (int k = 0; k < 4; k++) m[k] = rsp_s[k].ready;
    return m;
  endfunction

  function automatic reg_a48_d32_req_t mk(input logic wr, input logic [47:0] a, input logic [31:0] d);
    reg_a48_d32_req_t r;
    r.valid = 1'b1;
    r.write = wr;
    r.addr  = a;
    r.wdata = d;
    r.wstrb = 4'hF;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_ni = 1'b0;
    req_s  = '0;
    #2;
    // Reset state
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_grant", 64'(grant_idx_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_tidx", 64'(timeout_idx_o), 64'd0);
    chk("rst_req_o", 64'(req_o.valid), 64'd0);
    chk("rst_rsp", 64'(rdy_mask()), 64'd0);
    #10 rst_ni = 1'b1;
    tick();

    // Single write from requester 2, zero-wait target
    tgt_lat  = 0;
    req_s[2] = mk(1'b1, 48'h0000_1000_0020, 32'hCAFE_0002);
    tick();
    chk("wr_busy", 64'(busy_o), 64'd1);
    chk("wr_grant", 64'(grant_idx_o), 64'd2);
    chk("wr_valid", 64'(req_o.valid), 64'd1);
    chk("wr_addr", 64'(req_o.addr), 64'h0000_1000_0020);
    chk("wr_wdata", 64'(req_o.wdata), 64'hCAFE_0002);
    chk("wr_rdy", 64'(rdy_mask()), 64'b0100);
    tick();
    req_s[2].valid = 1'b0;
    chk("wr_idle", 64'(busy_o), 64'd0);
    // Pointer now 3: with 0 and 3 both waiting, 3 wins
    req_s[0] = mk(1'b0, 48'h0, 32'h0);
    req_s[3] = mk(1'b0, 48'h0, 32'h0);
    tick();
    chk("ptr3_grant", 64'(grant_idx_o), 64'd3);
    tick();
    req_s = '0;

    // All four continuously valid: grants 0,1,2,3,0 alternating with arbitration cycles
    for (int k = 0; k < 4; k++) req_s[k] = mk(1'b0, 48'(k), 32'h0);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c % 2 == 0) begin
        chk("rr_grant", 64'(grant_idx_o), 64'((c / 2) % 4));
        chk("rr_mask", 64'(rdy_mask()), 64'(4'b0001 << ((c / 2) % 4)));
      end else begin
        chk("rr_idle_mask", 64'(rdy_mask()), 64'd0);
      end
    end
    req_s = '0;

    // Read from requester 1, target waits 5 cycles
    tgt_lat   = 5;
    tgt_rdata = 32'h1234_5678;
    req_s[1]  = mk(1'b0, 48'h0000_0000_0040, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("rd_busy", 64'(busy_o), 64'd1);
      chk("rd_rdy", 64'(rsp_s[1].ready), 64'(c == 6));
    end
    chk("rd_rdata", 64'(rsp_s[1].rdata), 64'h1234_5678);
    chk("rd_err", 64'(rsp_s[1].error), 64'd0);
    tick();
    req_s[1].valid = 1'b0;
    chk("rd_busy_end", 64'(busy_o), 64'd0);

    // Timeout: requester 1, target never ready; requester 2 arrives meanwhile
    tgt_lat  = -1;
    req_s[1] = mk(1'b0, 48'h0000_2000_0010, 32'h0);
    tick();
    chk("to_grant", 64'(grant_idx_o), 64'd1);
    req_s[2] = mk(1'b1, 48'h0000_3000_0000, 32'h2222_2222);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      if (c < 8) begin
        chk("to_pulse_early", 64'(timeout_o), 64'd0);
        chk("to_mask_early", 64'(rdy_mask()), 64'd0);
      end
    end
    chk("to_pulse", 64'(timeout_o), 64'd1);
    chk("to_mask", 64'(rdy_mask()), 64'b0010);
    chk("to_rdata", 64'(rsp_s[1].rdata), 64'hBADC_AB1E);
    chk("to_err", 64'(rsp_s[1].error), 64'd1);
    chk("to_req_vld", 64'(req_o.valid), 64'd0);
    tick();
    req_s[1].valid = 1'b0;
    tgt_force      = 1'b1;
    #1;
    chk("to_pulse_once", 64'(timeout_o), 64'd0);
    chk("to_tidx", 64'(timeout_idx_o), 64'd1);
    chk("late_rdy_mask", 64'(rdy_mask()), 64'd0);
    tgt_force = 1'b0;
    tgt_lat   = 0;
    tick();
    chk("after_to_grant", 64'(grant_idx_o), 64'd2);
    chk("after_to_mask", 64'(rdy_mask()), 64'b0100);
    tick();
    req_s[2].valid = 1'b0;

    // Target ready exactly when the watchdog would fire: normal completion
    tgt_lat   = 7;
    tgt_err   = 1'b1;
    tgt_rdata = 32'h0BAD_F00D;
    req_s[3]  = mk(1'b1, 48'h0000_4000_0000, 32'h3333_3333);
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("race_pulse", 64'(timeout_o), 64'd0);
    end
    chk("race_mask", 64'(rdy_mask()), 64'b1000);
    chk("race_rdata", 64'(rsp_s[3].rdata), 64'h0BAD_F00D);
    chk("race_err", 64'(rsp_s[3].error), 64'd1);
    tick();
    req_s[3].valid = 1'b0;
    tgt_err        = 1'b0;
    chk("race_tidx", 64'(timeout_idx_o), 64'd1);

    // Requester 0 drops valid mid-transaction
    tgt_lat  = -1;
    req_s[0] = mk(1'b0, 48'h0, 32'h0);
    tick();
    chk("drop_grant", 64'(grant_idx_o), 64'd0);
    chk("drop_vld_before", 64'(req_o.valid), 64'd1);
    req_s[0].valid = 1'b0;
    #1;
    chk("drop_vld_after", 64'(req_o.valid), 64'd0);
    chk("drop_mask", 64'(rdy_mask()), 64'd0);
    tick();
    chk("drop_idle", 64'(busy_o), 64'd0);

    // Reset mid-BUSY, then first grant goes to requester 0
    for (int k = 0; k < 4; k++) req_s[k] = mk(1'b0, 48'(k), 32'h0);
    tick();
    chk("mid_grant", 64'(grant_idx_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_grant", 64'(grant_idx_o), 64'd0);
    chk("arst_tidx", 64'(timeout_idx_o), 64'd0);
    chk("arst_req_vld", 64'(req_o.valid), 64'd0);
    chk("arst_mask", 64'(rdy_mask()), 64'd0);
    #1 rst_ni = 1'b1;
    tick();
    chk("post_rst_grant", 64'(grant_idx_o), 64'd0);
    chk("post_rst_busy", 64'(busy_o), 64'd1);
    req_s = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
